// File: rtl/abc_pkg.sv
// Shared constants and types for the add-drum constant EEPROM reader.
package abc_pkg;

  localparam int unsigned NUM_SLOTS_DEFAULT = 50;
  localparam int unsigned MAX_DIGIT         = 9;
  localparam int unsigned MAX_DECADE        = 14;
  localparam int unsigned SLOT_W            = 6;
  localparam int unsigned DIGIT_W           = 4;
  localparam int unsigned DECADE_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } reader_state_t;

  // True when the requested address has no ROM content behind it.
  function automatic logic req_out_of_range(input logic [DIGIT_W-1:0]  digit,
                                            input logic [DECADE_W-1:0] decade);
    return (digit > DIGIT_W'(MAX_DIGIT)) || (decade > DECADE_W'(MAX_DECADE));
  endfunction

endpackage

// File: rtl/eeprom_slot_timer.sv
// Per-slot wait counter for the EEPROM reader; with EEPROM_READER_DUAL_READ_EN
// a slot spans two access windows and is sampled at the end of each.
module eeprom_slot_timer
  import abc_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic sample_c,
  output logic slot_end_c
);

`ifdef EEPROM_READER_DUAL_READ_EN
  localparam int unsigned PERIOD = 2 * ACCESS_CYCLES;
`else
  localparam int unsigned PERIOD = ACCESS_CYCLES;
`endif
  localparam int unsigned CNT_W = $clog2(PERIOD) + 1;

  logic [CNT_W-1:0] cnt;

  // Cycle count since the current slot address was applied.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == CNT_W'(PERIOD - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign slot_end_c = run && (cnt == CNT_W'(PERIOD - 1));

`ifdef EEPROM_READER_DUAL_READ_EN
  assign sample_c = run && ((cnt == CNT_W'(ACCESS_CYCLES - 1)) || slot_end_c);
`else
  assign sample_c = slot_end_c;
`endif

endmodule

// File: rtl/eeprom_reader.sv
// Handshaked sequencing reader for the add-drum constant EEPROM.
// Optional EEPROM_READER_DUAL_READ_EN samples every slot twice and flags disagreement.
module eeprom_reader
  import abc_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned NUM_SLOTS     = NUM_SLOTS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DIGIT_W-1:0]   req_digit,
  input  logic [DECADE_W-1:0]  req_decade,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [NUM_SLOTS-1:0] resp_word,
  output logic                 resp_err,
  output logic [DIGIT_W-1:0]   digit,
  output logic [DECADE_W-1:0]  decade,
  output logic [SLOT_W-1:0]    time_slot,
  output logic                 ce_n,
  output logic                 oe_n,
  output logic                 we_n,
  input  logic                 data
);

  reader_state_t        state;
  logic                 start_c;
  logic                 run_c;
  logic                 sample_c;
  logic                 slot_end_c;
  logic                 last_slot_c;
  logic [NUM_SLOTS-1:0] slot_mask_c;
`ifdef EEPROM_READER_DUAL_READ_EN
  logic                 first_bit;
`endif

  assign start_c     = (state == IDLE) && req_valid;
  assign run_c       = (state == READ);
  assign last_slot_c = (time_slot == SLOT_W'(NUM_SLOTS - 1));
  assign slot_mask_c = NUM_SLOTS'(1) << time_slot;
  assign we_n        = 1'b1;

  eeprom_slot_timer #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (start_c),
    .run        (run_c),
    .sample_c   (sample_c),
    .slot_end_c (slot_end_c)
  );

  // Request/response sequencer; address and strobes only move while reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_word  <= '0;
      resp_err   <= 1'b0;
      digit      <= '0;
      decade     <= '0;
      time_slot  <= '0;
      ce_n       <= 1'b1;
      oe_n       <= 1'b1;
`ifdef EEPROM_READER_DUAL_READ_EN
      first_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            resp_word <= '0;
            if (req_out_of_range(req_digit, req_decade)) begin
              state    <= DONE;
              resp_err <= 1'b1;
            end else if (req_digit == '0) begin
              // Digit-0 ROM rows are undefined; the answer is known to be zero.
              state    <= DONE;
              resp_err <= 1'b0;
            end else begin
              state     <= READ;
              resp_err  <= 1'b0;
              digit     <= req_digit;
              decade    <= req_decade;
              time_slot <= '0;
              ce_n      <= 1'b0;
              oe_n      <= 1'b0;
            end
          end
        end

        READ: begin
          if (sample_c) begin
            // Under dual read the second sample overwrites the first.
            resp_word <= data ? (resp_word | slot_mask_c) : (resp_word & ~slot_mask_c);
`ifdef EEPROM_READER_DUAL_READ_EN
            if (!slot_end_c) begin
              first_bit <= data;
            end else if (data != first_bit) begin
              resp_err <= 1'b1;
            end
`endif
          end
          if (slot_end_c) begin
            if (last_slot_c) begin
              ce_n       <= 1'b1;
              oe_n       <= 1'b1;
              state      <= DONE;
              resp_valid <= 1'b1;
            end else begin
              time_slot <= time_slot + SLOT_W'(1);
            end
          end
        end

        DONE: begin
          // Fast-path entries raise resp_valid one cycle after the accept.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          ce_n       <= 1'b1;
          oe_n       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_reader.sv
// Directed bench for eeprom_reader with a timing-aware EEPROM model.
module tb_eeprom_reader;

`ifdef EEPROM_READER_DUAL_READ_EN
  localparam int LAT = 200;
`else
  localparam int LAT = 100;
`endif
  localparam int LIMIT = 450;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_digit;
  logic [3:0]  req_decade;
  logic        resp_valid;
  logic        resp_ready;
  logic [49:0] resp_word;
  logic        resp_err;
  logic [3:0]  digit;
  logic [3:0]  decade;
  logic [5:0]  time_slot;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic        data;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  eeprom_reader dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_digit  (req_digit),
    .req_decade (req_decade),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_word  (resp_word),
    .resp_err   (resp_err),
    .digit      (digit),
    .decade     (decade),
    .time_slot  (time_slot),
    .ce_n       (ce_n),
    .oe_n       (oe_n),
    .we_n       (we_n),
    .data       (data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // EEPROM model: a bit is only correct once its slot address has been held
  // across one edge; before that it drives the inverse.
  function automatic logic [63:0] rom_word(input logic [3:0] d, input logic [3:0] dc);
    logic [63:0] v;
    v = 64'(d);
    for (int i = 0; i < int'(dc); i++) v = v * 64'd10;
    return v;
  endfunction

  logic [5:0]  slot_q = '0;
  int          age = 0;
  logic        flip_en = 1'b0;
  logic        ce_low = 1'b0;
  logic        ce_clr = 1'b0;
  logic [63:0] rom_w;
  logic        rom_b;
  logic        flip;

  always @(posedge clk) begin
    slot_q <= time_slot;
    age    <= (time_slot == slot_q) ? age + 1 : 1;
    if (ce_clr) ce_low <= 1'b0;
    else if (!ce_n) ce_low <= 1'b1;
  end

  assign rom_w = rom_word(digit, decade);
  assign rom_b = rom_w[time_slot];
  assign flip  = flip_en && (time_slot == 6'd5) && (age >= 2);
  assign data  = (ce_n || oe_n) ? 1'b0 :
                 (time_slot == slot_q) ? (rom_b ^ flip) : ~rom_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic [3:0] dc, output int e0);
    @(negedge clk);
    req_digit  = d;
    req_decade = dc;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    e0        = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int e0, output int lat);
    lat = -1;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = cyc - e0;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("ack_idle", 64'({req_ready, resp_valid}), 64'b10);
  endtask

  task automatic read_word(input string tag, input logic [3:0] d, input logic [3:0] dc,
                           input int exp_lat, input logic [49:0] exp_w, input logic exp_e);
    int e0, lat;
    send(d, dc, e0);
    wait_resp(e0, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_word"}, 64'(resp_word), 64'(exp_w));
    check({tag, "_err"}, 64'(resp_err), 64'(exp_e));
    ack();
  endtask

  initial begin
    int e0, lat;
    bit seen;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_digit  = '0;
    req_decade = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_word", 64'(resp_word), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    check("rst_addr", 64'({digit, decade, time_slot}), 64'd0);
    check("rst_strobes", 64'({ce_n, oe_n, we_n}), 64'b111);
    @(negedge clk);
    rst = 1'b0;

    read_word("d3e2", 4'd3, 4'd2, LAT, 50'h12C, 1'b0);
    read_word("d9e14", 4'd9, 4'd14, LAT, 50'h3328B944C4000, 1'b0);

    // Fast paths never touch the EEPROM.
    @(negedge clk);
    ce_clr = 1'b1;
    @(negedge clk);
    ce_clr = 1'b0;
    read_word("d0e5", 4'd0, 4'd5, 1, 50'h0, 1'b0);
    read_word("d4e15", 4'd4, 4'd15, 1, 50'h0, 1'b1);
    read_word("d10e3", 4'd10, 4'd3, 1, 50'h0, 1'b1);
    check("fast_ce", 64'(ce_low), 64'd0);

    // Response held off while a stray request is presented.
    send(4'd7, 4'd3, e0);
    wait_resp(e0, lat);
    check("hold_lat", 64'(lat), 64'(LAT));
    @(negedge clk);
    req_digit  = 4'd2;
    req_decade = 4'd1;
    req_valid  = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("hold_word", 64'(resp_word), 64'h1B58);
    check("hold_flags", 64'({resp_valid, req_ready}), 64'b10);
    check("hold_addr", 64'(digit), 64'd7);
    req_valid = 1'b0;
    ack();

    // Reset in the middle of slot 17.
    send(4'd5, 4'd4, e0);
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk);
      #1;
      if (time_slot == 6'd17) break;
    end
    check("slot17_reached", 64'(time_slot), 64'd17);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_strobes", 64'({ce_n, oe_n}), 64'b11);
    check("midrst_slot", 64'(time_slot), 64'd0);
    check("midrst_flags", 64'({resp_valid, req_ready}), 64'b01);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (LAT + 10) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check("midrst_no_resp", 64'(seen), 64'd0);
    read_word("d1e0", 4'd1, 4'd0, LAT, 50'h1, 1'b0);

`ifdef EEPROM_READER_DUAL_READ_EN
    // Data flips between the two samples of slot 5; second sample is kept.
    flip_en = 1'b1;
    read_word("dual_flip", 4'd3, 4'd2, 200, 50'h10C, 1'b1);
    flip_en = 1'b0;
    read_word("dual_clean", 4'd2, 4'd0, 200, 50'h2, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
